// File: rtl/trace_checker.sv
// Trace checker: compares an incoming register-update trace against a preloaded expected-record table.
// Optional macro TRACE_CHECKER_CAPTURE_EN adds got/expected capture of the first diverging record.
module trace_checker #(
  parameter int PC_WIDTH    = 8,
  parameter int REG_WIDTH   = 4,
  parameter int VALUE_WIDTH = 8,
  parameter int DEPTH       = 16,
  localparam int CNT_WIDTH  = $clog2(DEPTH + 1),
  localparam int IDX_WIDTH  = $clog2(DEPTH)
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   load_valid,
  input  logic [IDX_WIDTH-1:0]   load_index,
  input  logic [PC_WIDTH-1:0]    load_pc,
  input  logic [REG_WIDTH-1:0]   load_reg,
  input  logic [VALUE_WIDTH-1:0] load_value,
  input  logic [CNT_WIDTH-1:0]   expected_count,
  input  logic                   start,
  input  logic                   rec_valid,
  output logic                   rec_ready,
  input  logic [PC_WIDTH-1:0]    rec_pc,
  input  logic [REG_WIDTH-1:0]   rec_reg,
  input  logic [VALUE_WIDTH-1:0] rec_value,
  output logic                   busy,
  output logic                   done,
  output logic                   pass,
  output logic [CNT_WIDTH-1:0]   checked,
  output logic [CNT_WIDTH-1:0]   fail_index
`ifdef TRACE_CHECKER_CAPTURE_EN
  ,
  output logic [PC_WIDTH-1:0]    fail_got_pc,
  output logic [REG_WIDTH-1:0]   fail_got_reg,
  output logic [VALUE_WIDTH-1:0] fail_got_value,
  output logic [PC_WIDTH-1:0]    fail_exp_pc,
  output logic [REG_WIDTH-1:0]   fail_exp_reg,
  output logic [VALUE_WIDTH-1:0] fail_exp_value
`endif
);

  localparam int REC_WIDTH = PC_WIDTH + REG_WIDTH + VALUE_WIDTH;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_PASS, S_FAIL} state_t;

  state_t                 state_q, state_d;
  logic [CNT_WIDTH-1:0]   count_q, count_d;
  logic [CNT_WIDTH-1:0]   checked_q, checked_d;
  logic [CNT_WIDTH-1:0]   fail_index_q, fail_index_d;
  logic [REC_WIDTH-1:0]   mem [DEPTH];
  logic [REC_WIDTH-1:0]   rd_q;
  logic [REC_WIDTH-1:0]   rec_word;
  logic [CNT_WIDTH-1:0]   start_count;
  logic [CNT_WIDTH-1:0]   checked_inc;
  logic                   handshake;
  logic                   match;

  assign rec_word    = {rec_pc, rec_reg, rec_value};
  assign rec_ready   = (state_q != S_IDLE);
  assign handshake   = rec_valid & rec_ready;
  assign match       = (rec_word == rd_q);
  assign start_count = (expected_count > CNT_WIDTH'(DEPTH)) ? CNT_WIDTH'(DEPTH) : expected_count;
  assign checked_inc = checked_q + CNT_WIDTH'(1);

  assign busy       = (state_q == S_RUN);
  assign done       = (state_q == S_PASS) || (state_q == S_FAIL);
  assign pass       = (state_q == S_PASS);
  assign checked    = checked_q;
  assign fail_index = fail_index_q;

  always_ff @(posedge clock) begin
    if (load_valid && state_q != S_RUN) begin
      mem[load_index] <= {load_pc, load_reg, load_value};
    end
  end

  // Prefetch the entry the next record will be compared against, so the
  // compare in RUN uses a registered RAM output.
  always_ff @(posedge clock) begin
    rd_q <= mem[checked_d[IDX_WIDTH-1:0]];
  end

`ifdef TRACE_CHECKER_CAPTURE_EN
  logic [REC_WIDTH-1:0] cap_got_q, cap_got_d;
  logic [REC_WIDTH-1:0] cap_exp_q, cap_exp_d;

  assign {fail_got_pc, fail_got_reg, fail_got_value} = cap_got_q;
  assign {fail_exp_pc, fail_exp_reg, fail_exp_value} = cap_exp_q;
`endif

  always_comb begin
    state_d      = state_q;
    count_d      = count_q;
    checked_d    = checked_q;
    fail_index_d = fail_index_q;
`ifdef TRACE_CHECKER_CAPTURE_EN
    cap_got_d    = cap_got_q;
    cap_exp_d    = cap_exp_q;
`endif
    case (state_q)
      S_RUN: begin
        if (handshake) begin
          if (match) begin
            checked_d = checked_inc;
            if (checked_inc == count_q) state_d = S_PASS;
          end else begin
            fail_index_d = checked_q;
            state_d      = S_FAIL;
`ifdef TRACE_CHECKER_CAPTURE_EN
            cap_got_d    = rec_word;
            cap_exp_d    = rd_q;
`endif
          end
        end
      end
      default: begin
        if (start) begin
          count_d      = start_count;
          checked_d    = '0;
          fail_index_d = '0;
          state_d      = (start_count == '0) ? S_PASS : S_RUN;
`ifdef TRACE_CHECKER_CAPTURE_EN
          cap_got_d    = '0;
          cap_exp_d    = '0;
`endif
        end else if (state_q == S_PASS && handshake) begin
          // Overrun: the engine executed more steps than the model trace holds.
          fail_index_d = count_q;
          state_d      = S_FAIL;
`ifdef TRACE_CHECKER_CAPTURE_EN
          cap_got_d    = rec_word;
          cap_exp_d    = '0;
`endif
        end
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q      <= S_IDLE;
      count_q      <= '0;
      checked_q    <= '0;
      fail_index_q <= '0;
`ifdef TRACE_CHECKER_CAPTURE_EN
      cap_got_q    <= '0;
      cap_exp_q    <= '0;
`endif
    end else begin
      state_q      <= state_d;
      count_q      <= count_d;
      checked_q    <= checked_d;
      fail_index_q <= fail_index_d;
`ifdef TRACE_CHECKER_CAPTURE_EN
      cap_got_q    <= cap_got_d;
      cap_exp_q    <= cap_exp_d;
`endif
    end
  end

endmodule

// File: tb/tb_trace_checker.sv
// Bench for trace_checker: directed runs checked every cycle against a trace-level model.
module tb_trace_checker;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       load_valid = 1'b0;
  logic [3:0] load_index = '0;
  logic [7:0] load_pc = '0;
  logic [3:0] load_reg = '0;
  logic [7:0] load_value = '0;
  logic [4:0] expected_count = '0;
  logic       start = 1'b0;
  logic       rec_valid = 1'b0;
  logic       rec_ready;
  logic [7:0] rec_pc = '0;
  logic [3:0] rec_reg = '0;
  logic [7:0] rec_value = '0;
  logic       busy, done, pass;
  logic [4:0] checked, fail_index;
`ifdef TRACE_CHECKER_CAPTURE_EN
  logic [7:0] fail_got_pc, fail_exp_pc;
  logic [3:0] fail_got_reg, fail_exp_reg;
  logic [7:0] fail_got_value, fail_exp_value;
`endif

  int checks = 0;
  int errors = 0;

  trace_checker dut (
    .clock(clock), .reset(reset),
    .load_valid(load_valid), .load_index(load_index),
    .load_pc(load_pc), .load_reg(load_reg), .load_value(load_value),
    .expected_count(expected_count), .start(start),
    .rec_valid(rec_valid), .rec_ready(rec_ready),
    .rec_pc(rec_pc), .rec_reg(rec_reg), .rec_value(rec_value),
    .busy(busy), .done(done), .pass(pass),
    .checked(checked), .fail_index(fail_index)
`ifdef TRACE_CHECKER_CAPTURE_EN
    ,
    .fail_got_pc(fail_got_pc), .fail_got_reg(fail_got_reg), .fail_got_value(fail_got_value),
    .fail_exp_pc(fail_exp_pc), .fail_exp_reg(fail_exp_reg), .fail_exp_value(fail_exp_value)
`endif
  );

  always #5 clock = ~clock;

  // Model: the host table, the snapshot a run compares against, and every record accepted since start.
  logic [19:0] m_tab  [16];
  logic [19:0] m_snap [16];
  logic [19:0] m_got  [$];
  bit          m_active = 1'b0;
  int          m_count = 0;

  typedef struct packed {
    logic        busy;
    logic        done;
    logic        pass;
    logic        ready;
    logic [4:0]  checked;
    logic [4:0]  fail;
    logic [19:0] got;
    logic [19:0] expv;
  } exp_t;

  function automatic exp_t derive();
    exp_t e;
    int len, lim, mis, i;
    e = '0;
    if (!m_active) return e;
    len = m_got.size();
    lim = (len < m_count) ? len : m_count;
    mis = -1;
    i = 0;
    while (i < lim && mis < 0) begin
      if (m_got[i] !== m_snap[i]) mis = i;
      i++;
    end
    e.ready = 1'b1;
    if (mis >= 0) begin
      e.done = 1'b1; e.fail = 5'(mis); e.checked = 5'(mis);
      e.got = m_got[mis]; e.expv = m_snap[mis];
    end else if (len > m_count) begin
      e.done = 1'b1; e.fail = 5'(m_count); e.checked = 5'(m_count);
      e.got = m_got[m_count];
    end else if (len == m_count) begin
      e.done = 1'b1; e.pass = 1'b1; e.checked = 5'(m_count);
    end else begin
      e.busy = 1'b1; e.checked = 5'(len);
    end
    return e;
  endfunction

  exp_t m_e;
  always @(posedge clock or negedge reset) begin
    if (!reset) begin
      m_active = 1'b0;
      m_got.delete();
    end else begin
      m_e = derive();
      if (start && !m_e.busy) begin
        m_snap   = m_tab;
        m_count  = (expected_count > 5'd16) ? 16 : int'(expected_count);
        m_active = 1'b1;
        m_got.delete();
        $display("start count=%0d", m_count);
      end else if (rec_valid && m_e.ready) begin
        m_got.push_back({rec_pc, rec_reg, rec_value});
        $display("rec #%0d pc=%0h reg=%0h val=%0h", m_got.size() - 1, rec_pc, rec_reg, rec_value);
      end
      if (load_valid && !m_e.busy) m_tab[load_index] = {load_pc, load_reg, load_value};
    end
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] expv);
    checks++;
    if (got !== expv) begin
      errors++;
      $display("FAIL %s got %0h expected %0h at %0t", name, got, expv, $time);
    end
  endtask

  exp_t c_e;
  always @(negedge clock) begin
    c_e = derive();
    chk("busy", 32'(busy), 32'(c_e.busy));
    chk("done", 32'(done), 32'(c_e.done));
    chk("pass", 32'(pass), 32'(c_e.pass));
    chk("rec_ready", 32'(rec_ready), 32'(c_e.ready));
    chk("checked", 32'(checked), 32'(c_e.checked));
    chk("fail_index", 32'(fail_index), 32'(c_e.fail));
`ifdef TRACE_CHECKER_CAPTURE_EN
    chk("fail_got", 32'({fail_got_pc, fail_got_reg, fail_got_value}), 32'(c_e.got));
    chk("fail_exp", 32'({fail_exp_pc, fail_exp_reg, fail_exp_value}), 32'(c_e.expv));
`endif
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic gap(input int n);
    repeat (n) tick();
  endtask

  task automatic load(input int idx, input int pc, input int r, input int v);
    load_valid = 1'b1; load_index = 4'(idx);
    load_pc = 8'(pc); load_reg = 4'(r); load_value = 8'(v);
    tick();
    load_valid = 1'b0;
  endtask

  task automatic send(input int pc, input int r, input int v);
    rec_valid = 1'b1; rec_pc = 8'(pc); rec_reg = 4'(r); rec_value = 8'(v);
    tick();
    rec_valid = 1'b0;
  endtask

  task automatic run_start(input int cnt);
    expected_count = 5'(cnt); start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  initial begin
    gap(2);
    chk("lit reset busy", 32'(busy), 32'd0);
    chk("lit reset ready", 32'(rec_ready), 32'd0);
    reset = 1'b1;
    gap(1);

    // Exact 4-record match, back-to-back.
    for (int i = 0; i < 4; i++) load(i, i, i, i);
    run_start(4);
    chk("lit t1 busy", 32'(busy), 32'd1);
    for (int i = 0; i < 4; i++) send(i, i, i);
    chk("lit t1 done", 32'(done), 32'd1);
    chk("lit t1 pass", 32'(pass), 32'd1);
    chk("lit t1 checked", 32'(checked), 32'd4);

    // Value mismatch on record 2.
    run_start(4);
    send(0, 0, 0); send(1, 1, 1); send(2, 2, 5); send(3, 3, 3);
    chk("lit t2 done", 32'(done), 32'd1);
    chk("lit t2 pass", 32'(pass), 32'd0);
    chk("lit t2 fail_index", 32'(fail_index), 32'd2);
    chk("lit t2 checked", 32'(checked), 32'd2);
`ifdef TRACE_CHECKER_CAPTURE_EN
    chk("lit t2 got_value", 32'(fail_got_value), 32'd5);
    chk("lit t2 exp_value", 32'(fail_exp_value), 32'd2);
`endif

    // Empty run passes immediately.
    run_start(0);
    chk("lit t3 pass", 32'(pass), 32'd1);
    chk("lit t3 checked", 32'(checked), 32'd0);
    chk("lit t3 ready", 32'(rec_ready), 32'd1);

    // Overrun after a passing run, then FAIL keeps accepting.
    run_start(4);
    for (int i = 0; i < 4; i++) send(i, i, i);
    send(9, 9, 9);
    chk("lit t4 pass", 32'(pass), 32'd0);
    chk("lit t4 fail_index", 32'(fail_index), 32'd4);
    send(1, 1, 1);
    chk("lit t4 hold", 32'(fail_index), 32'd4);

    // Gaps between records and a table write during RUN that must be ignored.
    run_start(4);
    send(0, 0, 0);
    gap(2);
    load(1, 7, 7, 7);
    send(1, 1, 1);
    gap(1);
    send(2, 2, 2);
    gap(3);
    send(3, 3, 3);
    chk("lit t5 pass", 32'(pass), 32'd1);
    chk("lit t5 checked", 32'(checked), 32'd4);

    // Reset mid-run, then rerun without reloading.
    run_start(4);
    send(0, 0, 0); send(1, 1, 1);
    reset = 1'b0;
    #2;
    chk("lit t6 busy", 32'(busy), 32'd0);
    chk("lit t6 done", 32'(done), 32'd0);
    chk("lit t6 checked", 32'(checked), 32'd0);
    chk("lit t6 ready", 32'(rec_ready), 32'd0);
    tick();
    reset = 1'b1;
    gap(1);
    run_start(4);
    for (int i = 0; i < 4; i++) send(i, i, i);
    chk("lit t6 pass", 32'(pass), 32'd1);

    // Count above DEPTH clamps to a full 16-entry run.
    for (int i = 0; i < 16; i++) load(i, i * 3, i, 255 - i);
    run_start(20);
    for (int i = 0; i < 16; i++) send(i * 3, i, 255 - i);
    chk("lit t7 pass", 32'(pass), 32'd1);
    chk("lit t7 checked", 32'(checked), 32'd16);

    // Register-field mismatch on the first record.
    run_start(2);
    send(0, 5, 255);
    chk("lit t8 fail_index", 32'(fail_index), 32'd0);
    chk("lit t8 done", 32'(done), 32'd1);

    // PC-field mismatch on the second record.
    run_start(3);
    send(0, 0, 255); send(4, 1, 254);
    gap(1);
    chk("lit t9 fail_index", 32'(fail_index), 32'd1);
    chk("lit t9 checked", 32'(checked), 32'd1);

    gap(2);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
